// File: rtl/icache_nway_multi_word_pkg.sv
// Shared definitions for the set-associative instruction cache:
// default geometry, controller state encoding and the NOP fill value.
package icache_nway_multi_word_pkg;

    // Default build: 1 KB, 4-way, 8 words of 32 bits per block
    localparam int DEF_ADDR_WIDTH    = 32;
    localparam int DEF_DATA_WIDTH    = 32;
    localparam int DEF_CACHE_SIZE    = 1024;
    localparam int DEF_ASSOCIATIVITY = 4;
    localparam int DEF_BLOCK_SIZE    = 8;

    // Geometry derived from the default build
    localparam int BYTE_BITS   = $clog2(DEF_DATA_WIDTH / 8);
    localparam int WORD_BITS   = $clog2(DEF_BLOCK_SIZE);
    localparam int OFFSET_BITS = BYTE_BITS + WORD_BITS;
    localparam int NUM_SETS    = DEF_CACHE_SIZE / (DEF_ASSOCIATIVITY * DEF_BLOCK_SIZE * (DEF_DATA_WIDTH / 8));
    localparam int INDEX_BITS  = $clog2(NUM_SETS);
    localparam int TAG_BITS    = DEF_ADDR_WIDTH - OFFSET_BITS - INDEX_BITS;

    // Instruction returned whenever the fetch port is not hitting
    localparam logic [31:0] NOP = 32'h0000_0013;

    // Refill controller states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        FILL = 2'd2
    } state_t;

endpackage

// File: rtl/icache_nway_multi_word_victim_sel.sv
// Picks the way to refill in one set: the lowest-indexed invalid way,
// or the set's round-robin pointer once every way holds a line.
module icache_victim_sel #(
    parameter int WAYS  = 4,
    parameter int WAY_W = 2
) (
    input  logic [WAYS-1:0]  valid_vec,
    input  logic [WAY_W-1:0] rr_ptr,
    output logic [WAY_W-1:0] victim_way,
    output logic             victim_valid
);

    // Scan from the top way down so the lowest invalid way wins
    always_comb begin
        victim_way   = rr_ptr;
        victim_valid = &valid_vec;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_vec[w]) begin
                victim_way = WAY_W'(w);
            end else begin
                victim_way = victim_way;
            end
        end
    end

endmodule

// File: rtl/icache_nway_multi_word.sv
// Read-only set-associative instruction cache. Hits are served
// combinationally from the flop-based data array; a miss stalls the
// fetch port and refills the whole block through one memory burst.
module icache_nway_multi_word
    import icache_nway_multi_word_pkg::*;
#(
    parameter int ADDR_WIDTH    = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int CACHE_SIZE    = 1024,
    parameter int ASSOCIATIVITY = 4,
    parameter int BLOCK_SIZE    = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cpu_req,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    output logic [DATA_WIDTH-1:0] cpu_data,
    output logic                  cpu_valid,
    output logic                  cpu_stall,
    output logic                  mem_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [3:0]            mem_burst_len,
    input  logic [DATA_WIDTH-1:0] mem_data,
    input  logic                  mem_ready,
    input  logic                  mem_valid,
    input  logic                  mem_last,
    output logic                  cache_hit,
    output logic                  cache_miss,
    output logic                  cache_evict
);

    localparam int BYTE_W      = $clog2(DATA_WIDTH / 8);
    localparam int WORD_W      = $clog2(BLOCK_SIZE);
    localparam int OFF_W       = BYTE_W + WORD_W;
    localparam int BLOCK_BYTES = BLOCK_SIZE * (DATA_WIDTH / 8);
    localparam int SETS        = CACHE_SIZE / (ASSOCIATIVITY * BLOCK_BYTES);
    localparam int IDX_W       = $clog2(SETS);
    localparam int TAG_W       = ADDR_WIDTH - OFF_W - IDX_W;
    localparam int WAY_W       = $clog2(ASSOCIATIVITY);
    localparam logic [ADDR_WIDTH-1:0] BLK_MASK = ~ADDR_WIDTH'(BLOCK_BYTES - 1);

    // Line storage
    logic [ASSOCIATIVITY-1:0] valid_r [SETS];
    logic [WAY_W-1:0]         rr_r    [SETS];
    logic [TAG_W-1:0]         tag_r   [SETS][ASSOCIATIVITY];
    logic [DATA_WIDTH-1:0]    data_r  [SETS][ASSOCIATIVITY][BLOCK_SIZE];

    // Refill controller state
    state_t                  state_r;
    logic [ADDR_WIDTH-1:0]   blk_addr_r;
    logic [WORD_W-1:0]       cnt_r;
    logic                    mem_req_r;

    // Decoded fetch address and latched refill address
    logic [TAG_W-1:0]  req_tag_s;
    logic [IDX_W-1:0]  req_idx_s;
    logic [WORD_W-1:0] req_word_s;
    logic [TAG_W-1:0]  fill_tag_s;
    logic [IDX_W-1:0]  fill_idx_s;
    logic              lookup_hit_s;
    logic [WAY_W-1:0]  hit_way_s;
    logic [WAY_W-1:0]  victim_way_s;
    logic              victim_valid_s;
    logic              fill_we_s;
    logic              fill_last_s;

    assign req_tag_s  = cpu_addr[ADDR_WIDTH-1 -: TAG_W];
    assign req_idx_s  = cpu_addr[OFF_W +: IDX_W];
    assign req_word_s = cpu_addr[BYTE_W +: WORD_W];
    assign fill_tag_s = blk_addr_r[ADDR_WIDTH-1 -: TAG_W];
    assign fill_idx_s = blk_addr_r[OFF_W +: IDX_W];

    // Burst words are only accepted while out of reset and filling
    assign fill_we_s   = rst && (state_r == FILL) && mem_valid;
    assign fill_last_s = fill_we_s && mem_last;

    assign mem_req       = mem_req_r;
    assign mem_addr      = blk_addr_r;
    assign mem_burst_len = 4'(BLOCK_SIZE - 1);

    // Victim choice for the set currently being refilled; the set's
    // valid bits cannot change until the fill completes
    icache_victim_sel #(
        .WAYS  (ASSOCIATIVITY),
        .WAY_W (WAY_W)
    ) u_victim_sel (
        .valid_vec    (valid_r[fill_idx_s]),
        .rr_ptr       (rr_r[fill_idx_s]),
        .victim_way   (victim_way_s),
        .victim_valid (victim_valid_s)
    );

    // Tag compare across every valid way of the indexed set
    always_comb begin
        lookup_hit_s = 1'b0;
        hit_way_s    = '0;
        for (int w = 0; w < ASSOCIATIVITY; w++) begin
            if (valid_r[req_idx_s][w] && (tag_r[req_idx_s][w] == req_tag_s)) begin
                lookup_hit_s = 1'b1;
                hit_way_s    = WAY_W'(w);
            end else begin
                lookup_hit_s = lookup_hit_s;
                hit_way_s    = hit_way_s;
            end
        end
    end

    // Fetch-port response and statistics strobes
    always_comb begin
        cpu_data    = DATA_WIDTH'(NOP);
        cpu_valid   = 1'b0;
        cpu_stall   = 1'b0;
        cache_hit   = 1'b0;
        cache_miss  = 1'b0;
        cache_evict = 1'b0;
        case (state_r)
            IDLE: begin
                if (cpu_req && lookup_hit_s) begin
                    cpu_data  = data_r[req_idx_s][hit_way_s][req_word_s];
                    cpu_valid = 1'b1;
                    cache_hit = 1'b1;
                end else if (cpu_req) begin
                    cpu_stall  = 1'b1;
                    cache_miss = 1'b1;
                end else begin
                    cpu_stall  = 1'b0;
                end
            end
            REQ: begin
                cpu_stall = 1'b1;
            end
            FILL: begin
                cpu_stall   = 1'b1;
                cache_evict = mem_valid && mem_last && victim_valid_s;
            end
            default: begin
                cpu_stall = 1'b1;
            end
        endcase
    end

    // Refill controller, valid bits and round-robin pointers
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r    <= IDLE;
            mem_req_r  <= 1'b0;
            blk_addr_r <= '0;
            cnt_r      <= '0;
            for (int s = 0; s < SETS; s++) begin
                valid_r[s] <= '0;
                rr_r[s]    <= '0;
            end
        end else begin
            case (state_r)
                IDLE: begin
                    if (cpu_req && !lookup_hit_s) begin
                        blk_addr_r <= cpu_addr & BLK_MASK;
                        mem_req_r  <= 1'b1;
                        state_r    <= REQ;
                    end
                end
                REQ: begin
                    if (mem_ready) begin
                        mem_req_r <= 1'b0;
                        cnt_r     <= '0;
                        state_r   <= FILL;
                    end
                end
                FILL: begin
                    if (mem_valid) begin
                        cnt_r <= cnt_r + WORD_W'(1);
                    end
                    if (mem_valid && mem_last) begin
                        valid_r[fill_idx_s][victim_way_s] <= 1'b1;
                        rr_r[fill_idx_s] <= rr_r[fill_idx_s] + WAY_W'(1);
                        state_r <= IDLE;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    mem_req_r <= 1'b0;
                end
            endcase
        end
    end

    // Burst words land in the victim way; the tag is written with the last word
    always_ff @(posedge clk) begin
        if (fill_we_s) begin
            data_r[fill_idx_s][victim_way_s][cnt_r] <= mem_data;
        end
        if (fill_last_s) begin
            tag_r[fill_idx_s][victim_way_s] <= fill_tag_s;
        end
    end

endmodule

// File: tb/tb_icache_nway_multi_word.sv
// Directed and randomized bench for icache_nway_multi_word. The reference
// model tracks which memory blocks are resident in each set; hit data is
// simply the memory image, since the cache is a read-only copy of it.
module tb_icache_nway_multi_word;
    import icache_nway_multi_word_pkg::*;

    localparam int WAYS = DEF_ASSOCIATIVITY;
    localparam int BLKW = DEF_BLOCK_SIZE;

    logic        clk;
    logic        rst;
    logic        cpu_req;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_data;
    logic        cpu_valid;
    logic        cpu_stall;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [3:0]  mem_burst_len;
    logic [31:0] mem_data;
    logic        mem_ready;
    logic        mem_valid;
    logic        mem_last;
    logic        cache_hit;
    logic        cache_miss;
    logic        cache_evict;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: resident block addresses per set and way
    logic [31:0] res_blk [NUM_SETS][WAYS];
    bit          res_v   [NUM_SETS][WAYS];
    int          rr_ptr  [NUM_SETS];

    icache_nway_multi_word dut (
        .clk           (clk),
        .rst           (rst),
        .cpu_req       (cpu_req),
        .cpu_addr      (cpu_addr),
        .cpu_data      (cpu_data),
        .cpu_valid     (cpu_valid),
        .cpu_stall     (cpu_stall),
        .mem_req       (mem_req),
        .mem_addr      (mem_addr),
        .mem_burst_len (mem_burst_len),
        .mem_data      (mem_data),
        .mem_ready     (mem_ready),
        .mem_valid     (mem_valid),
        .mem_last      (mem_last),
        .cache_hit     (cache_hit),
        .cache_miss    (cache_miss),
        .cache_evict   (cache_evict)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory image: block 0 holds 0x1000..0x1007
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h0000_1000 + (a >> 2) + ((a >> 8) << 16);
    endfunction

    function automatic int set_of(input logic [31:0] a);
        return int'((a >> OFFSET_BITS) % NUM_SETS);
    endfunction

    function automatic bit model_resident(input logic [31:0] blk);
        int s;
        bit r;
        s = set_of(blk);
        r = 1'b0;
        for (int w = 0; w < WAYS; w++)
            if (res_v[s][w] && res_blk[s][w] == blk) r = 1'b1;
        return r;
    endfunction

    task automatic model_clear();
        for (int s = 0; s < NUM_SETS; s++) begin
            rr_ptr[s] = 0;
            for (int w = 0; w < WAYS; w++) begin
                res_v[s][w]   = 1'b0;
                res_blk[s][w] = 32'h0;
            end
        end
    endtask

    // Place blk in its set; report whether a valid line was displaced
    task automatic model_fill(input logic [31:0] blk, output bit ev);
        int s;
        int v;
        s = set_of(blk);
        v = -1;
        for (int w = 0; w < WAYS; w++)
            if (!res_v[s][w] && v < 0) v = w;
        if (v < 0) v = rr_ptr[s];
        ev = res_v[s][v];
        res_blk[s][v] = blk;
        res_v[s][v]   = 1'b1;
        rr_ptr[s]     = (rr_ptr[s] + 1) % WAYS;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b0;
        cpu_req   = 1'b0;
        mem_ready = 1'b0;
        mem_valid = 1'b0;
        mem_last  = 1'b0;
        cyc();
        rst = 1'b1;
        model_clear();
    endtask

    task automatic chk_idle_hit(input logic [31:0] a);
        chk("hit_valid", cpu_valid, 32'd1);
        chk("hit_data", cpu_data, mem_word(a));
        chk("hit_stall", cpu_stall, 32'd0);
        chk("hit_strobe", cache_hit, 32'd1);
        chk("hit_nomiss", cache_miss, 32'd0);
    endtask

    // One fetch; on a miss serve the burst with the given ready delay and gaps
    task automatic fetch(input logic [31:0] a, input int rdly, input bit gap);
        logic [31:0] blk;
        bit ev;
        blk = a & 32'hFFFF_FFE0;
        cpu_req   = 1'b1;
        cpu_addr  = a;
        mem_ready = 1'b0;
        mem_valid = 1'b0;
        mem_last  = 1'b0;
        #4;
        if (model_resident(blk)) begin
            chk_idle_hit(a);
            cyc();
        end else begin
            chk("miss_strobe", cache_miss, 32'd1);
            chk("miss_stall", cpu_stall, 32'd1);
            chk("miss_valid", cpu_valid, 32'd0);
            chk("miss_data", cpu_data, NOP);
            chk("miss_nohit", cache_hit, 32'd0);
            cyc();
            for (int k = 0; k <= rdly; k++) begin
                cpu_addr  = $urandom & 32'hFFFF_FFFC;
                mem_ready = (k == rdly);
                #4;
                chk("req_mem_req", mem_req, 32'd1);
                chk("req_mem_addr", mem_addr, blk);
                chk("req_burst_len", {28'd0, mem_burst_len}, 32'd7);
                chk("req_stall", cpu_stall, 32'd1);
                chk("req_valid", cpu_valid, 32'd0);
                cyc();
            end
            mem_ready = 1'b0;
            model_fill(blk, ev);
            for (int i = 0; i < BLKW; i++) begin
                cpu_addr = $urandom & 32'hFFFF_FFFC;
                if (gap) begin
                    mem_valid = 1'b0;
                    mem_last  = 1'b0;
                    #4;
                    chk("gap_stall", cpu_stall, 32'd1);
                    chk("gap_mem_req", mem_req, 32'd0);
                    cyc();
                end
                mem_valid = 1'b1;
                mem_data  = mem_word(blk + 32'(4 * i));
                mem_last  = (i == BLKW - 1);
                #4;
                chk("fill_stall", cpu_stall, 32'd1);
                chk("fill_mem_req", mem_req, 32'd0);
                chk("fill_evict", cache_evict, (i == BLKW - 1) ? {31'd0, ev} : 32'd0);
                cyc();
            end
            mem_valid = 1'b0;
            mem_last  = 1'b0;
            cpu_addr  = a;
            #4;
            chk_idle_hit(a);
            cyc();
        end
    endtask

    task automatic idle_check(input logic [31:0] a);
        cpu_req  = 1'b0;
        cpu_addr = a;
        #4;
        chk("noreq_hit", cache_hit, 32'd0);
        chk("noreq_miss", cache_miss, 32'd0);
        chk("noreq_stall", cpu_stall, 32'd0);
        chk("noreq_data", cpu_data, NOP);
        chk("noreq_valid", cpu_valid, 32'd0);
        cyc();
    endtask

    initial begin
        rst       = 1'b0;
        cpu_req   = 1'b0;
        cpu_addr  = 32'h0;
        mem_data  = 32'h0;
        mem_ready = 1'b0;
        mem_valid = 1'b0;
        mem_last  = 1'b0;
        model_clear();
        cyc();
        #4;
        chk("rst_mem_req", mem_req, 32'd0);
        chk("rst_cpu_valid", cpu_valid, 32'd0);
        chk("rst_evict", cache_evict, 32'd0);
        chk("rst_stall", cpu_stall, 32'd0);
        cyc();
        rst = 1'b1;

        // Cold fetch of block 0, then every word of it hits
        fetch(32'h0000_0000, 0, 1'b0);
        for (int i = 0; i < BLKW; i++) fetch(32'(4 * i), 0, 1'b0);

        // Mid-block PC refills the aligned block and returns word 5
        do_reset();
        fetch(32'h0000_0014, 0, 1'b0);

        // Five blocks in set 0: the fifth displaces the oldest
        do_reset();
        for (int b = 0; b < 5; b++) fetch(32'(b * 256), 0, 1'b0);
        fetch(32'h0000_0100, 0, 1'b0);
        fetch(32'h0000_0000, 0, 1'b0);

        // Slow handshake and gapped burst
        fetch(32'h0000_0524, 3, 1'b1);

        // Reset after four burst words abandons the refill
        cpu_req  = 1'b1;
        cpu_addr = 32'h0000_0648;
        #4;
        chk("abort_miss", cache_miss, 32'd1);
        cyc();
        mem_ready = 1'b1;
        #4;
        chk("abort_req", mem_req, 32'd1);
        cyc();
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            mem_valid = 1'b1;
            mem_data  = mem_word(32'h0000_0640 + 32'(4 * i));
            #4;
            chk("abort_fill_stall", cpu_stall, 32'd1);
            cyc();
        end
        mem_valid = 1'b0;
        rst       = 1'b0;
        cpu_req   = 1'b0;
        cyc();
        rst = 1'b1;
        model_clear();
        #4;
        chk("abort_mem_req", mem_req, 32'd0);
        chk("abort_stall", cpu_stall, 32'd0);
        cyc();
        fetch(32'h0000_0648, 0, 1'b0);

        // No request: quiet port even for a resident address
        idle_check(32'h0000_0648);

        // Randomized fetch stream over a few tags per set
        for (int n = 0; n < 150; n++) begin
            logic [31:0] a;
            a = (32'($urandom_range(0, 5)) << 8) | (32'($urandom_range(0, 7)) << 5)
                | (32'($urandom_range(0, 7)) << 2);
            if ($urandom_range(0, 4) == 0) idle_check(a);
            else fetch(a, int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
